// File: rtl/icache_fill_fsm_pkg.sv
// Shared definitions for the cache block fill FSM and the cache arrays.
//  - Fixed geometry: address and data widths and words per block.
//  - Offset, tag and index split constants used by the cache arrays.
//  - State encoding of the fill FSM.
//  - Helpers that align a miss address to its block and build a word offset.
package icache_fill_fsm_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;                        // power of two
    localparam int WORD_IDX_W  = $clog2(BLOCK_WORDS);
    localparam int OFFSET_BITS = $clog2(2 * BLOCK_WORDS);  // byte offset within a block
    localparam int CNT_W       = WORD_IDX_W + 1;           // counters must reach BLOCK_WORDS

    // Tag/index split used by the cache arrays.
    localparam int INDEX_BITS  = 4;
    localparam int TAG_BITS    = ADDR_W - OFFSET_BITS - INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Clear the in-block byte offset of an address.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    // Byte offset of a halfword within the block.
    function automatic logic [ADDR_W-1:0] word_offset(input logic [WORD_IDX_W-1:0] idx);
        return {{(ADDR_W-OFFSET_BITS){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/icache_fill_fsm_if.sv
// Bundle of the miss, memory and cache-array signals of the fill FSM.
//  master : the fill FSM (consumes miss/memory response, drives request and array writes)
//  slave  : the surrounding cache and memory (drive miss/response, consume the rest)
interface icache_fill_fsm_if;
    import icache_fill_fsm_pkg::*;

    logic                  miss_detected;
    logic [ADDR_W-1:0]     miss_address;
    logic                  memory_data_valid;
    logic [DATA_W-1:0]     memory_data;
    logic                  fsm_busy;
    logic                  mem_req;
    logic [ADDR_W-1:0]     memory_address;
    logic                  write_data_array;
    logic [WORD_IDX_W-1:0] fill_word_idx;
    logic [DATA_W-1:0]     fill_data;
    logic                  write_tag_array;

    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_req, memory_address, write_data_array,
               fill_word_idx, fill_data, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_req, memory_address, write_data_array,
               fill_word_idx, fill_data, write_tag_array
    );
endinterface

// File: rtl/icache_fill_fsm_counter.sv
// Fill counter: WIDTH+1 bit up-counter so it can hold the value BLOCK_WORDS.
//  clk, rst_n : clock, asynchronous active-low reset (count to 0)
//  clr        : synchronous clear, takes priority over inc
//  inc        : increment enable
//  count      : current value
module icache_fill_fsm_counter #(
    parameter int WIDTH = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [WIDTH:0] count
);
    logic [WIDTH:0] count_reg, count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count_reg + {{WIDTH{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/icache_fill_fsm.sv
// Cache miss handler: fetches a whole aligned block from pipelined main memory.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : master side of icache_fill_fsm_if
//      miss_detected/miss_address     -> start a fill of the block holding the address
//      mem_req/memory_address         <- one halfword request per cycle, no gaps
//      memory_data_valid/memory_data  -> in-order responses, any latency
//      write_data_array/fill_word_idx/fill_data <- data array write per response
//      write_tag_array                <- with the last word; marks the block valid
//      fsm_busy                       <- fill in progress, fetch stalls on it
// Requests and responses are tracked by independent counters, so responses may
// overlap the request burst; only the response count ends the fill.
module icache_fill_fsm
    import icache_fill_fsm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    icache_fill_fsm_if.master bus
);
    localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    fill_state_e       state_reg, state_next;
    logic [ADDR_W-1:0] base_reg, base_next;

    // Index 0 counts issued requests, index 1 counts received responses.
    logic              cnt_clr;
    logic [1:0]        cnt_inc;
    logic [CNT_W-1:0]  cnt_val [2];
    logic [CNT_W-1:0]  req_cnt, rcv_cnt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            icache_fill_fsm_counter #(.WIDTH(WORD_IDX_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (cnt_clr),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign req_cnt = cnt_val[0];
    assign rcv_cnt = cnt_val[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            base_reg  <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        base_next            = base_reg;
        cnt_clr              = 1'b0;
        cnt_inc              = 2'b00;
        bus.fsm_busy         = 1'b0;
        bus.mem_req          = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.fill_word_idx    = '0;
        bus.fill_data        = '0;
        bus.write_tag_array  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Responses seen here are stray and ignored.
                if (bus.miss_detected) begin
                    state_next = FILL;
                    base_next  = block_base(bus.miss_address);
                    cnt_clr    = 1'b1;
                end
            end
            FILL: begin
                bus.fsm_busy = 1'b1;
                if (req_cnt < ALL_WORDS) begin
                    bus.mem_req        = 1'b1;
                    bus.memory_address = base_reg + word_offset(req_cnt[WORD_IDX_W-1:0]);
                    cnt_inc[0]         = 1'b1;
                end
                if (bus.memory_data_valid && (rcv_cnt < ALL_WORDS)) begin
                    bus.write_data_array = 1'b1;
                    bus.fill_word_idx    = rcv_cnt[WORD_IDX_W-1:0];
                    bus.fill_data        = bus.memory_data;
                    cnt_inc[1]           = 1'b1;
                    // The tag goes in with the last word; a miss in this
                    // cycle is not looked at because we are still in FILL.
                    if (rcv_cnt == LAST_WORD) begin
                        bus.write_tag_array = 1'b1;
                        state_next          = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
